// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage MIPS pipeline: load-use stalls, branch/jump
// flushes, data-memory wait freezes, plus stall/flush performance counters.
module hazard_ctrl #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             id_jump,
    input  logic             idex_memread,
    input  logic [REG_W-1:0] idex_rt,
    input  logic             ex_branch_taken,
    input  logic             dmem_busy,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             pipe_hold,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_WAIT  = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic             redir_pend_q, redir_pend_d;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0] flush_events_q, flush_events_d;

    logic lu;
    logic branch_flush;

    always_comb begin
        // The STALL term lets the stalled instruction through after exactly one bubble.
        lu = idex_memread && (idex_rt != '0)
             && ((idex_rt == id_rs) || (id_uses_rt && (idex_rt == id_rt)))
             && (state_q != ST_STALL);
        branch_flush = ex_branch_taken || redir_pend_q;

        state_d      = ST_RUN;
        redir_pend_d = redir_pend_q;
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        pipe_hold    = 1'b0;

        if (dmem_busy) begin
            state_d    = ST_WAIT;
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            pipe_hold  = 1'b1;
            // A redirect seen while frozen is replayed on the first free cycle.
            redir_pend_d = redir_pend_q | ex_branch_taken;
        end else if (branch_flush) begin
            state_d      = ST_FLUSH;
            ifid_flush   = 1'b1;
            idex_flush   = 1'b1;
            redir_pend_d = 1'b0;
        end else if (id_jump) begin
            state_d    = ST_FLUSH;
            ifid_flush = 1'b1;
        end else if (lu) begin
            state_d    = ST_STALL;
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
        end

        stall_cycles_d = stall_cycles_q;
        if (((state_d == ST_WAIT) || (state_d == ST_STALL)) && (stall_cycles_q != '1))
            stall_cycles_d = stall_cycles_q + CNT_ONE;

        flush_events_d = flush_events_q;
        if ((state_d == ST_FLUSH) && (flush_events_q != '1))
            flush_events_d = flush_events_q + CNT_ONE;

        // Reset forces a safe pipeline: nothing advances and both stage registers bubble.
        if (!reset_n) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            pipe_hold  = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_RUN;
            redir_pend_q   <= 1'b0;
            stall_cycles_q <= '0;
            flush_events_q <= '0;
        end else begin
            state_q        <= state_d;
            redir_pend_q   <= redir_pend_d;
            stall_cycles_q <= stall_cycles_d;
            flush_events_q <= flush_events_d;
        end
    end

    assign state        = state_q;
    assign stall_cycles = stall_cycles_q;
    assign flush_events = flush_events_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized traffic
// compared against a behavioural pipeline-control model.
module tb_hazard_ctrl;

    localparam int REG_W = 5;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk;
    logic             reset_n;
    logic [REG_W-1:0] id_rs, id_rt, idex_rt;
    logic             id_uses_rt, id_jump, idex_memread, ex_branch_taken, dmem_busy;
    logic             pc_write, ifid_write, ifid_flush, idex_flush, pipe_hold;
    logic [1:0]       state;
    logic [CNT_W-1:0] stall_cycles, flush_events;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: class of the previous cycle, pending redirect, event counts.
    int m_prev;
    bit m_pend;
    int m_stalls;
    int m_flushes;

    hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt), .id_jump(id_jump),
        .idex_memread(idex_memread), .idex_rt(idex_rt),
        .ex_branch_taken(ex_branch_taken), .dmem_busy(dmem_busy),
        .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .idex_flush(idex_flush), .pipe_hold(pipe_hold), .state(state),
        .stall_cycles(stall_cycles), .flush_events(flush_events)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // 0 RUN, 1 STALL (load-use), 2 WAIT, 3 FLUSH
    function automatic int model_class();
        bit hazard;
        hazard = idex_memread && (idex_rt != 0) &&
                 ((idex_rt == id_rs) || (id_uses_rt && idex_rt == id_rt)) && (m_prev != 1);
        if (dmem_busy) return 2;
        if (ex_branch_taken || m_pend) return 3;
        if (id_jump) return 3;
        if (hazard) return 1;
        return 0;
    endfunction

    task automatic model_reset();
        m_prev = 0; m_pend = 0; m_stalls = 0; m_flushes = 0;
    endtask

    task automatic check_outputs(input string ctx);
        int c;
        bit e_pc, e_ifw, e_iff, e_idf, e_hold;
        c = model_class();
        e_pc = 1; e_ifw = 1; e_iff = 0; e_idf = 0; e_hold = 0;
        if (!reset_n) begin
            e_pc = 0; e_ifw = 0; e_iff = 1; e_idf = 1;
        end else if (c == 2) begin
            e_pc = 0; e_ifw = 0; e_hold = 1;
        end else if (c == 3) begin
            e_iff = 1;
            e_idf = ex_branch_taken || m_pend;
        end else if (c == 1) begin
            e_pc = 0; e_ifw = 0; e_idf = 1;
        end
        check({ctx, ".pc_write"},     32'(pc_write),     32'(e_pc));
        check({ctx, ".ifid_write"},   32'(ifid_write),   32'(e_ifw));
        check({ctx, ".ifid_flush"},   32'(ifid_flush),   32'(e_iff));
        check({ctx, ".idex_flush"},   32'(idex_flush),   32'(e_idf));
        check({ctx, ".pipe_hold"},    32'(pipe_hold),    32'(e_hold));
        check({ctx, ".state"},        32'(state),        32'(m_prev));
        check({ctx, ".stall_cycles"}, 32'(stall_cycles), 32'(m_stalls));
        check({ctx, ".flush_events"}, 32'(flush_events), 32'(m_flushes));
    endtask

    // Called with inputs settled at posedge+1; samples mid-cycle, then clocks the model.
    task automatic step(input string ctx);
        int c;
        #3;
        check_outputs(ctx);
        c = model_class();
        @(posedge clk);
        if (!reset_n) begin
            model_reset();
        end else begin
            if (dmem_busy)  m_pend = m_pend | ex_branch_taken;
            else if (c == 3 && (ex_branch_taken || m_pend)) m_pend = 0;
            if ((c == 1 || c == 2) && m_stalls < CMAX) m_stalls++;
            if (c == 3 && m_flushes < CMAX) m_flushes++;
            m_prev = c;
        end
        #1;
    endtask

    task automatic clear_inputs();
        id_rs = '0; id_rt = '0; idex_rt = '0;
        id_uses_rt = 0; id_jump = 0; idex_memread = 0; ex_branch_taken = 0; dmem_busy = 0;
    endtask

    task automatic do_reset();
        reset_n = 0;
        model_reset();
        step("reset");
        reset_n = 1;
    endtask

    initial begin
        clear_inputs();
        reset_n = 0;
        model_reset();
        @(posedge clk); #1;
        step("reset");
        check("reset.ifid_flush_const", 32'(ifid_flush), 32'd1);
        reset_n = 1;

        // Load-use: one bubble, then the stall is masked.
        idex_memread = 1; idex_rt = 5'd8; id_rs = 5'd8;
        #3;
        check("lu.pc_write", 32'(pc_write), 32'd0);
        check("lu.idex_flush", 32'(idex_flush), 32'd1);
        #(-0);
        @(posedge clk); m_prev = 1; m_stalls = 1; #1;
        #3;
        check("lu2.pc_write", 32'(pc_write), 32'd1);
        check("lu2.idex_flush", 32'(idex_flush), 32'd0);
        check("lu2.state", 32'(state), 32'd1);
        check("lu2.stall_cycles", 32'(stall_cycles), 32'd1);
        @(posedge clk); m_prev = 0; #1;
        clear_inputs();

        // Zero register and rt gating.
        do_reset();
        idex_memread = 1; idex_rt = 0; id_rs = 0;
        step("zero_reg");
        idex_rt = 5'd5; id_rt = 5'd5; id_rs = 5'd1; id_uses_rt = 0;
        step("rt_gate");
        check("rt_gate.state", 32'(state), 32'd0);
        id_uses_rt = 1;
        step("rt_used");
        clear_inputs();

        // Branch overrides load-use and jump.
        do_reset();
        idex_memread = 1; idex_rt = 5'd8; id_rs = 5'd8; id_jump = 1; ex_branch_taken = 1;
        step("br_prio");
        clear_inputs();
        step("br_prio_after");
        check("br_prio.flush_events", 32'(flush_events), 32'd1);

        // Deferred redirect through a three-cycle memory wait.
        do_reset();
        dmem_busy = 1;
        step("defer_w1");
        ex_branch_taken = 1;
        step("defer_w2");
        ex_branch_taken = 0;
        step("defer_w3");
        dmem_busy = 0;
        #3;
        check("defer.flush_idex", 32'(idex_flush), 32'd1);
        check("defer.flush_ifid", 32'(ifid_flush), 32'd1);
        #(-0);
        @(posedge clk); m_prev = 3; m_pend = 0; m_stalls = 3; m_flushes = 1; #1;
        step("defer_run");
        check("defer.stall_cycles", 32'(stall_cycles), 32'd3);
        check("defer.flush_events", 32'(flush_events), 32'd1);

        // Asynchronous reset mid-wait drops a pending redirect.
        do_reset();
        dmem_busy = 1; ex_branch_taken = 1;
        step("rst_mid_w1");
        ex_branch_taken = 0;
        step("rst_mid_w2");
        #2;
        reset_n = 0;
        #1;
        check("rst_mid.idex_flush", 32'(idex_flush), 32'd1);
        check("rst_mid.ifid_flush", 32'(ifid_flush), 32'd1);
        check("rst_mid.stall_cycles", 32'(stall_cycles), 32'd0);
        check("rst_mid.state", 32'(state), 32'd0);
        model_reset();
        @(posedge clk); #1;
        reset_n = 1; dmem_busy = 0;
        step("rst_release");
        step("rst_release2");

        // Saturation: 20 wait cycles on a 4-bit counter.
        do_reset();
        dmem_busy = 1;
        for (int i = 0; i < 20; i++) step("sat");
        dmem_busy = 0;
        step("sat_end");
        check("sat.stall_cycles", 32'(stall_cycles), 32'd15);

        // Randomized traffic with occasional resets.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                clear_inputs();
                do_reset();
            end
            id_rs           = REG_W'($urandom_range(0, 3));
            id_rt           = REG_W'($urandom_range(0, 3));
            idex_rt         = REG_W'($urandom_range(0, 3));
            id_uses_rt      = $urandom_range(0, 1) == 1;
            idex_memread    = $urandom_range(0, 1) == 1;
            id_jump         = $urandom_range(0, 7) == 0;
            ex_branch_taken = $urandom_range(0, 7) == 0;
            dmem_busy       = $urandom_range(0, 3) == 0;
            step("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage MIPS core; it produces the `flush` that empties the ID/EX control bundle (the bubble path), plus the PC / IF/ID write enables and the IF/ID flush. It detects load-use hazards, taken-branch redirects from EX, J-type jumps in ID, and data-memory wait states. It holds a small state register, a deferred-redirect flag and two saturating performance counters. It sits beside the ID stage and drives the enables of the PC, IF/ID, ID/EX and later pipeline registers.

## Interface
- `REG_W`, default 5: register-specifier width.
- `CNT_W`, default 16: performance counter width.

- `clk`  in  1  core clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `id_rs`  in  REG_W  rs field of the instruction in ID.
- `id_rt`  in  REG_W  rt field of the instruction in ID.
- `id_uses_rt`  in  1  ID instruction reads rt (R-type, beq, sw).
- `id_jump`  in  1  J-type jump decoded in ID.
- `idex_memread`  in  1  instruction in EX is a load.
- `idex_rt`  in  REG_W  destination rt of that load.
- `ex_branch_taken`  in  1  single-cycle pulse: branch resolved taken in EX.
- `dmem_busy`  in  1  data memory not ready; the pipeline must freeze.
- `pc_write`  out  1  PC load enable.
- `ifid_write`  out  1  IF/ID load enable.
- `ifid_flush`  out  1  zero IF/ID on the next edge.
- `idex_flush`  out  1  bubble select into ID/EX (drives the bubble mux `flush`).
- `pipe_hold`  out  1  hold ID/EX, EX/MEM and MEM/WB.
- `state`  out  2  registered class of the previous cycle: RUN=0, STALL=1, WAIT=2, FLUSH=3.
- `stall_cycles`  out  CNT_W  count of STALL and WAIT cycles.
- `flush_events`  out  CNT_W  count of FLUSH cycles.

## Operation
- Load-use hazard (lu) is true when all of the following hold:
  - `idex_memread` = 1;
  - `idex_rt` != 0;
  - `idex_rt` == `id_rs`, or (`id_uses_rt` and `idex_rt` == `id_rt`);
  - `state` != STALL. This masks back-to-back stalls on the same load.
- Internal flag `redir_pend` is set when `ex_branch_taken` = 1 and `dmem_busy` = 1 in the same cycle.
- Decision per cycle, in priority order (default: `pc_write` = 1, `ifid_write` = 1, all other controls 0):
  1. **WAIT** (`dmem_busy` = 1):
     - `pc_write` = 0, `ifid_write` = 0, `pipe_hold` = 1, both flushes 0;
     - set `redir_pend` if `ex_branch_taken` = 1.
  2. **FLUSH, branch** (`ex_branch_taken` or `redir_pend`):
     - `ifid_flush` = 1, `idex_flush` = 1, `pc_write` = 1;
     - clear `redir_pend`.
  3. **FLUSH, jump** (`id_jump`): `ifid_flush` = 1 only.
  4. **STALL** (lu): `pc_write` = 0, `ifid_write` = 0, `idex_flush` = 1.
  5. **RUN**: defaults.
- A branch flush overrides lu and `id_jump`, because the ID instruction is discarded.
- `state` registers the class chosen in the current cycle.
- Counters:
  - `stall_cycles` increments in WAIT and STALL cycles;
  - `flush_events` increments in FLUSH cycles;
  - both saturate at all-ones and never wrap.
- While `reset_n` = 0:
  - `pc_write` = 0, `ifid_write` = 0, `pipe_hold` = 0, `ifid_flush` = 1, `idex_flush` = 1;
  - `state` = RUN, `redir_pend` = 0, both counters 0.
  - Assertion mid-operation discards any pending redirect immediately.

## Timing
- Control outputs are combinational from the current inputs, `state` and `redir_pend`: zero-cycle latency, valid before the same rising edge.
- `state`, `redir_pend` and the counters update on the rising edge. `state` and the counters reflect the decision one cycle later.
- Load-use costs exactly one bubble:
  - detection cycle = STALL;
  - next cycle `state` = STALL masks lu and the ID instruction proceeds.
- Deferred redirect: a branch pulse during WAIT produces the FLUSH on the first cycle with `dmem_busy` = 0, then clears.
- Reset release: the first edge with `reset_n` = 1 starts in RUN. Outputs change asynchronously on `reset_n` assertion.

## Test plan
- **Load-use:**
  - stimulus: `idex_memread` = 1, `idex_rt` = 8, `id_rs` = 8;
  - required: `pc_write` = 0, `ifid_write` = 0, `idex_flush` = 1;
  - next cycle (inputs unchanged): all controls RUN, `state` = 1, `stall_cycles` = 1.
- **Zero register and rt gating:**
  - `idex_rt` = 0 = `id_rs` → RUN;
  - `idex_rt` = 5 = `id_rt` with `id_uses_rt` = 0 → RUN.
- **Branch priority:**
  - stimulus: `ex_branch_taken` pulse with lu and `id_jump` also true;
  - required: `ifid_flush` = 1, `idex_flush` = 1, `pc_write` = 1, `flush_events` = 1.
- **Deferred redirect:**
  - stimulus: `dmem_busy` high 3 cycles, with the branch pulse in the 2nd cycle;
  - required: 3 WAIT cycles with `pipe_hold` = 1, then one FLUSH, then RUN;
  - counters: `stall_cycles` = 3, `flush_events` = 1.
- **Reset mid-operation:**
  - stimulus: `reset_n` low during WAIT with `redir_pend` set;
  - required: flushes = 1 immediately, counters 0;
  - after release with `dmem_busy` = 0: RUN, with no spurious flush.
- **Saturation:**
  - stimulus: `CNT_W` = 4, 20 continuous WAIT cycles;
  - required: `stall_cycles` holds at 15.
